// File: rtl/pll_supervisor_pkg.sv
// Shared types and widths for the PLL lock supervisor.
package pll_supervisor_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned RETRY_W  = 8;
  localparam int unsigned RELOCK_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  localparam logic [RELOCK_W-1:0] RELOCK_MAX = '1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, lock qualification and downstream reset release,
// with bounded retries and a sticky failure state.
module pll_lock_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES     = 100,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 10000,
  parameter int unsigned STABLE_CYCLES       = 1000,
  parameter int unsigned MAX_RETRIES         = 4
) (
  input  logic                refclk,
  input  logic                rst_n,
  input  logic                pll_locked_i,
  input  logic                sw_relock_i,
  output logic                pll_rst_o,
  output logic                sys_rst_n_o,
  output logic                pll_ready_o,
  output logic                lock_fail_o,
  output logic [RELOCK_W-1:0] relock_count_o,
  output logic [STATE_W-1:0]  state_o
);

  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RETRY_W-1:0]  retry_cnt, retry_d, retry_inc;
  logic [RELOCK_W-1:0] relock_cnt, relock_d;
  logic                lock_fail_q, lock_fail_d;
  logic                pll_rst_q, sys_rst_n_q, ready_q;
  logic                attempt_fail;
  logic                locked_s;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked_i),
    .q     (locked_s)
  );

  assign retry_inc = retry_cnt + RETRY_W'(1);

  // Next-state, counter and sticky-flag logic; software relock overrides all.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    retry_d      = retry_cnt;
    relock_d     = relock_cnt;
    lock_fail_d  = lock_fail_q;
    attempt_fail = 1'b0;

    if (sw_relock_i) begin
      state_d     = ST_RESET;
      cnt_d       = '0;
      retry_d     = '0;
      lock_fail_d = 1'b0;
    end else begin
      case (state_q)
        ST_RESET: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (locked_s)                   state_d      = ST_STABLE;
          else if (cnt_q == TIMEOUT_LAST) attempt_fail = 1'b1;
        end
        ST_STABLE: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!locked_s) begin
            attempt_fail = 1'b1;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            retry_d = '0;
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_d = ST_RESET;
            retry_d = '0;
            if (relock_cnt != RELOCK_MAX) relock_d = relock_cnt + RELOCK_W'(1);
          end
        end
        ST_FAIL: begin
          lock_fail_d = 1'b1;
        end
        default: state_d = ST_RESET;
      endcase

      if (attempt_fail) begin
        retry_d = retry_inc;
        state_d = (retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_RESET;
      end
      if (state_d == ST_FAIL) lock_fail_d = 1'b1;
      if (state_d != state_q) cnt_d = '0;
    end
  end

  // State and registered outputs, all decoded from the next state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      retry_cnt   <= '0;
      relock_cnt  <= '0;
      lock_fail_q <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_cnt   <= retry_d;
      relock_cnt  <= relock_d;
      lock_fail_q <= lock_fail_d;
      pll_rst_q   <= (state_d == ST_RESET) || (state_d == ST_FAIL);
      sys_rst_n_q <= (state_d == ST_RUN);
      ready_q     <= (state_d == ST_RUN);
    end
  end

  assign pll_rst_o      = pll_rst_q;
  assign sys_rst_n_o    = sys_rst_n_q;
  assign pll_ready_o    = ready_q;
  assign lock_fail_o    = lock_fail_q;
  assign relock_count_o = relock_cnt;
  assign state_o        = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with a countdown-based reference model.
module tb_pll_lock_supervisor;

  localparam int HOLD    = 4;
  localparam int TIMEOUT = 20;
  localparam int STABLE  = 8;
  localparam int MAXR    = 2;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked_i = 1'b0;
  logic       sw_relock_i  = 1'b0;
  logic       pll_rst_o, sys_rst_n_o, pll_ready_o, lock_fail_o;
  logic [7:0] relock_count_o;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  pll_lock_supervisor #(
    .RST_HOLD_CYCLES     (HOLD),
    .LOCK_TIMEOUT_CYCLES (TIMEOUT),
    .STABLE_CYCLES       (STABLE),
    .MAX_RETRIES         (MAXR)
  ) dut (
    .refclk         (refclk),
    .rst_n          (rst_n),
    .pll_locked_i   (pll_locked_i),
    .sw_relock_i    (sw_relock_i),
    .pll_rst_o      (pll_rst_o),
    .sys_rst_n_o    (sys_rst_n_o),
    .pll_ready_o    (pll_ready_o),
    .lock_fail_o    (lock_fail_o),
    .relock_count_o (relock_count_o),
    .state_o        (state_o)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phases with a remaining-cycle budget; sync modelled as a 2-deep history.
  int m_state   = 0;
  int m_left    = HOLD;
  int m_fails   = 0;
  int m_relocks = 0;
  bit m_flag    = 1'b0;
  bit s1 = 1'b0, s2 = 1'b0;

  always @(posedge refclk or negedge rst_n) begin
    bit ls;
    bit failed;
    if (!rst_n) begin
      m_state = 0; m_left = HOLD; m_fails = 0; m_relocks = 0; m_flag = 1'b0;
      s1 = 1'b0; s2 = 1'b0;
    end else begin
      ls = s2; s2 = s1; s1 = pll_locked_i;
      failed = 1'b0;
      if (sw_relock_i) begin
        m_state = 0; m_left = HOLD; m_fails = 0; m_flag = 1'b0;
      end else begin
        case (m_state)
          0: begin
            m_left--;
            if (m_left == 0) begin m_state = 1; m_left = TIMEOUT; end
          end
          1: begin
            if (ls) begin m_state = 2; m_left = STABLE; end
            else begin m_left--; if (m_left == 0) failed = 1'b1; end
          end
          2: begin
            if (!ls) failed = 1'b1;
            else begin m_left--; if (m_left == 0) begin m_state = 3; m_fails = 0; end end
          end
          3: begin
            if (!ls) begin
              m_state = 0; m_left = HOLD; m_fails = 0;
              if (m_relocks < 255) m_relocks++;
            end
          end
          default: ;
        endcase
        if (failed) begin
          m_fails++;
          if (m_fails == MAXR) begin m_state = 4; m_flag = 1'b1; end
          else begin m_state = 0; m_left = HOLD; end
        end
      end
    end
  end

  always @(negedge refclk) begin
    chk("state_o",     int'(state_o),        m_state);
    chk("pll_rst_o",   int'(pll_rst_o),      int'(m_state == 0 || m_state == 4));
    chk("sys_rst_n_o", int'(sys_rst_n_o),    int'(m_state == 3));
    chk("pll_ready_o", int'(pll_ready_o),    int'(m_state == 3));
    chk("lock_fail_o", int'(lock_fail_o),    int'(m_flag));
    chk("relock_cnt",  int'(relock_count_o), m_relocks);
    chk("retry_cnt",   int'(dut.retry_cnt),  m_fails);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int maxc, output int n);
    n = 0;
    while (state_o != s && n < maxc) begin
      @(posedge refclk);
      #1;
      n++;
    end
    if (state_o != s) chk("wait_state_timeout", int'(state_o), int'(s));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"},  int'(state_o),        0);
    chk({tag, "_pllrst"}, int'(pll_rst_o),      1);
    chk({tag, "_sysrst"}, int'(sys_rst_n_o),    0);
    chk({tag, "_ready"},  int'(pll_ready_o),    0);
    chk({tag, "_fail"},   int'(lock_fail_o),    0);
    chk({tag, "_relock"}, int'(relock_count_o), 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    cyc(3);
    chk_reset_outputs("por");

    // Power-up: 4-cycle PLL reset, lock two cycles later, 8 stable cycles.
    rst_n = 1'b1;
    wait_state(3'd1, 20, n);
    chk("rst_hold_len", n, 4);
    chk("pll_rst_fell", int'(pll_rst_o), 0);
    cyc(2);
    pll_locked_i = 1'b1;
    wait_state(3'd3, 40, n);
    chk("lock_to_run", n, 11);
    chk("run_sysrst", int'(sys_rst_n_o), 1);

    // One-cycle lock glitch in RUN.
    pll_locked_i = 1'b0;
    cyc(1);
    pll_locked_i = 1'b1;
    wait_state(3'd0, 10, n);
    chk("glitch_to_reset", n, 2);
    chk("glitch_sysrst", int'(sys_rst_n_o), 0);
    chk("glitch_relock", int'(relock_count_o), 1);
    wait_state(3'd3, 40, n);
    chk("relock_to_run", n, 13);

    // Lock lost permanently: two timeouts then FAIL.
    pll_locked_i = 1'b0;
    wait_state(3'd4, 100, n);
    chk("to_fail", n, 51);
    chk("fail_flag", int'(lock_fail_o), 1);
    chk("fail_relock", int'(relock_count_o), 2);
    cyc(30);
    chk("fail_held", int'(state_o), 4);
    chk("fail_pllrst", int'(pll_rst_o), 1);

    // Software relock out of FAIL.
    pll_locked_i = 1'b1;
    cyc(3);
    sw_relock_i = 1'b1;
    cyc(1);
    sw_relock_i = 1'b0;
    chk("sw_fail_clr", int'(lock_fail_o), 0);
    chk("sw_state", int'(state_o), 0);
    wait_state(3'd3, 40, n);
    chk("sw_to_run", n, 13);
    chk("sw_relock_kept", int'(relock_count_o), 2);

    // Lock drops during STABLE: retry then a good attempt.
    pll_locked_i = 1'b0;
    cyc(1);
    pll_locked_i = 1'b1;
    wait_state(3'd2, 40, n);
    cyc(4);
    pll_locked_i = 1'b0;
    cyc(1);
    pll_locked_i = 1'b1;
    wait_state(3'd0, 10, n);
    chk("stable_abort", n, 2);
    chk("stable_retry1", int'(dut.retry_cnt), 1);
    wait_state(3'd3, 40, n);
    chk("retry_to_run", n, 13);
    chk("retry_cleared", int'(dut.retry_cnt), 0);

    // Async reset mid-STABLE.
    pll_locked_i = 1'b0;
    cyc(1);
    pll_locked_i = 1'b1;
    wait_state(3'd2, 40, n);
    cyc(3);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("arst_stable");
    cyc(2);
    rst_n = 1'b1;
    wait_state(3'd3, 40, n);
    chk("post_arst_to_run", n, 13);

    // Async reset mid-RUN.
    cyc(2);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("arst_run");
    cyc(2);
    rst_n = 1'b1;
    cyc(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 Parameter RST_HOLD_CYCLES, default 100: refclk cycles the PLL reset is held (10 us at 10 MHz); legal range 1..65535.
REQ-002 Parameter LOCK_TIMEOUT_CYCLES, default 10000: maximum refclk cycles to wait for lock per attempt (1 ms); legal range 1..65535.
REQ-003 Parameter STABLE_CYCLES, default 1000: refclk cycles lock must hold continuously before downstream release; legal range 1..65535.
REQ-004 Parameter MAX_RETRIES, default 4: failed lock attempts before entering FAIL; legal range 1..255.
REQ-005 refclk  in  1  PLL reference clock (10 MHz); sole clock of the block.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 pll_locked_i  in  1  PLL locked output; asynchronous to refclk.
REQ-008 sw_relock_i  in  1  single-cycle request to restart the lock sequence.
REQ-009 pll_rst_o  out  1  active-high reset driven to the PLL rst input.
REQ-010 sys_rst_n_o  out  1  active-low reset for logic clocked by the PLL outputs.
REQ-011 pll_ready_o  out  1  high while in RUN.
REQ-012 lock_fail_o  out  1  sticky flag: retries exhausted.
REQ-013 relock_count_o  out  8  count of lock losses observed in RUN; saturates at 255.
REQ-014 state_o  out  3  current FSM state code.

Function
REQ-015 pll_locked_i SHALL pass through a 2-flop synchronizer (locked_s) before any use; 2-cycle latency.
REQ-016 FSM states and codes: RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4; codes 5-7 SHALL recover to RESET.
REQ-017 RESET: pll_rst_o=1; after RST_HOLD_CYCLES cycles in RESET, go to WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_rst_o=0; locked_s=1 -> STABLE; LOCK_TIMEOUT_CYCLES elapsed without lock -> attempt failure.
REQ-019 STABLE: locked_s=1 for STABLE_CYCLES consecutive cycles -> RUN; locked_s=0 at any point -> attempt failure.
REQ-020 Attempt failure: retry_cnt increments; if new retry_cnt == MAX_RETRIES go to FAIL, else go to RESET.
REQ-021 RUN: locked_s=0 -> RESET, relock_count_o increments (saturating), retry_cnt clears.
REQ-022 retry_cnt SHALL also clear on entry to RUN.
REQ-023 FAIL: pll_rst_o=1, lock_fail_o set and held; state is left only via sw_relock_i or rst_n.
REQ-024 sw_relock_i=1 in any state -> RESET next cycle, clears retry_cnt and lock_fail_o; relock_count_o unchanged; takes priority over all other transitions in the same cycle.
REQ-025 The cycle counter SHALL be 16 bits, clear on every state change, and not wrap (compare with ==).
REQ-026 sys_rst_n_o and pll_ready_o SHALL be registered, equal 1 exactly on cycles where state_o==RUN, and drop the cycle state leaves RUN.
REQ-027 pll_rst_o SHALL be registered and glitch-free, 1 in RESET and FAIL, 0 otherwise.

Reset
REQ-028 rst_n low SHALL asynchronously force: state RESET, pll_rst_o=1, sys_rst_n_o=0, pll_ready_o=0, lock_fail_o=0, relock_count_o=0, retry_cnt=0, counter=0, synchronizer flops=0.
REQ-029 On rst_n release the block SHALL begin a full RESET hold of RST_HOLD_CYCLES cycles.

Structure
REQ-030 State encoding, 16-bit counter width and retry/relock counter widths SHALL live in shared package pll_supervisor_pkg.
REQ-031 The 2-flop synchronizer SHALL be a separate sub-module sync_2ff with its own async active-low reset.
REQ-032 No combinational path from any input to any output.

Verification (RST_HOLD=4, LOCK_TIMEOUT=20, STABLE=8, MAX_RETRIES=2)
REQ-033 Release rst_n, raise pll_locked_i 2 cycles after pll_rst_o falls and hold it high -> pll_rst_o high 4 cycles, sys_rst_n_o rises after 8 stable cycles, state_o=3.
REQ-034 From RUN, drop pll_locked_i for 1 cycle -> state_o=0 after sync latency, sys_rst_n_o=0, relock_count_o=1, full relock sequence follows.
REQ-035 Keep pll_locked_i low -> two 20-cycle timeouts, then state_o=4, lock_fail_o=1, pll_rst_o=1 held indefinitely.
REQ-036 In FAIL, pulse sw_relock_i with pll_locked_i high -> lock_fail_o=0 next cycle, RESET, then RUN; relock_count_o unchanged.
REQ-037 Toggle pll_locked_i low at cycle 5 of STABLE -> retry_cnt=1, return to RESET; second good attempt reaches RUN with retry_cnt cleared.
REQ-038 Assert rst_n low mid-STABLE and mid-RUN -> all outputs at reset values immediately, without waiting for a refclk edge.
